// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// =============================================================================
// Module   : seq_restoring_divider_if
// Brief    : Operand and result valid/ready bundle for the restoring divider.
// Revision : 1.0 - initial release
// =============================================================================
interface seq_restoring_divider_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// =============================================================================
// Module   : seq_restoring_divider
// Brief    : Radix-2 restoring divider, one quotient bit per cycle, with
//            valid/ready handshakes on operand and result sides.
// Revision : 1.0 - initial release
// =============================================================================
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_restoring_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int PR_W  = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [DIVIDEND_W-1:0] work_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [PR_W-1:0]       prem_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic                  dz_q;

    logic                  w_accept;
    logic                  w_zero;
    logic                  w_last;
    logic [PR_W:0]         w_shifted;
    logic [PR_W:0]         w_diff;
    logic                  w_qbit;
    logic [PR_W-1:0]       w_prem_next;
    logic [DIVIDEND_W-1:0] w_work_next;

    assign w_accept    = bus.in_valid && (state_q == S_IDLE);
    assign w_zero      = (bus.divisor == '0);
    assign w_last      = (cnt_q == CNT_W'(1));
    assign w_shifted   = {prem_q, work_q[DIVIDEND_W-1]};
    assign w_diff      = w_shifted - {2'b00, dvs_q};
    // The top difference bit is the borrow: set means the trial went negative.
    assign w_qbit      = ~w_diff[PR_W];
    assign w_prem_next = w_qbit ? w_diff[PR_W-1:0] : w_shifted[PR_W-1:0];
    assign w_work_next = {work_q[DIVIDEND_W-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = w_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        work_q <= bus.dividend;
                        dvs_q  <= bus.divisor;
                        prem_q <= '0;
                        cnt_q  <= CNT_W'(DIVIDEND_W);
                        if (w_zero) begin
                            quo_q <= '1;
                            rem_q <= '0;
                            dz_q  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    prem_q <= w_prem_next;
                    work_q <= w_work_next;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    // Result registers change only on completion so they hold in IDLE/CALC.
                    if (w_last) begin
                        quo_q <= w_work_next;
                        rem_q <= w_prem_next[DIVISOR_W-1:0];
                        dz_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// =============================================================================
// Module   : tb_seq_restoring_divider
// Brief    : Self-checking bench: arithmetic reference model with scoreboard,
//            directed cases and randomized operand pairs with backpressure.
// Revision : 1.0 - initial release
// =============================================================================
module tb_seq_restoring_divider;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seq_restoring_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

    seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {quotient, remainder, div_zero} straight from unsigned arithmetic.
    function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) return {8'hFF, 4'h0, 1'b1};
        return {8'(a / b), 4'(a % b), 1'b0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    logic [12:0] sbq[$];

    // Everything is stable at the falling edge: check outputs, then book the
    // handshakes the coming rising edge will perform.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got q=%0d r=%0d z=%0d with no result pending",
                         bus.quotient, bus.remainder, bus.div_zero);
            end else if ({bus.quotient, bus.remainder, bus.div_zero} !== sbq[0]) begin
                bad++;
                $display("FAIL sb_result: got q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
                         bus.quotient, bus.remainder, bus.div_zero,
                         sbq[0][12:5], sbq[0][4:1], sbq[0][0]);
            end
            chk("no_overlap", int'(bus.in_ready), 0);
        end
        if (rst) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && sbq.size() > 0) void'(sbq.pop_front());
            if (bus.in_valid && bus.in_ready) sbq.push_back(model(bus.dividend, bus.divisor));
        end
    end

    task automatic send(input logic [7:0] a, input logic [3:0] b);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
    endtask

    // Latency counted in edges with the accepting edge as edge 1.
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", int'(bus.in_ready), 1);
        chk("idle_out_valid", int'(bus.out_valid), 0);
    endtask

    task automatic full_op(input logic [7:0] a, input logic [3:0] b, input int hold,
                           input bit lit, input logic [12:0] exp_lit);
        int          lat;
        logic [12:0] snap;
        send(a, b);
        wait_out(lat);
        chk("latency", lat, (b == 4'd0) ? 1 : 9);
        snap = {bus.quotient, bus.remainder, bus.div_zero};
        if (lit) chk("literal_result", int'(snap), int'(exp_lit));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'($urandom);
            bus.dividend = 8'($urandom);
            bus.divisor  = 4'($urandom);
            @(negedge clk);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_hold", int'({bus.quotient, bus.remainder, bus.div_zero}), int'(snap));
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        release_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] a;
        logic [3:0] b;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        chk("model_pin_200_7", int'(model(8'd200, 4'd7)), int'({8'd28, 4'd4, 1'b0}));
        chk("model_pin_77_0", int'(model(8'd77, 4'd0)), int'({8'hFF, 4'd0, 1'b1}));
        chk("model_pin_14_15", int'(model(8'd14, 4'd15)), int'({8'd0, 4'd14, 1'b0}));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_quotient", int'(bus.quotient), 0);
        chk("rst_remainder", int'(bus.remainder), 0);
        chk("rst_div_zero", int'(bus.div_zero), 0);

        full_op(8'd200, 4'd7,  0, 1'b1, {8'd28,  4'd4,  1'b0});
        full_op(8'd195, 4'd13, 1, 1'b1, {8'd15,  4'd0,  1'b0});
        full_op(8'd255, 4'd1,  0, 1'b1, {8'd255, 4'd0,  1'b0});
        full_op(8'd0,   4'd9,  0, 1'b1, {8'd0,   4'd0,  1'b0});
        full_op(8'd14,  4'd15, 2, 1'b1, {8'd0,   4'd14, 1'b0});
        full_op(8'd77,  4'd0,  2, 1'b1, {8'hFF,  4'd0,  1'b1});
        full_op(8'd143, 4'd11, 20, 1'b1, {8'd13, 4'd0,  1'b0});

        // New operands held valid across DONE wait for the result handshake.
        send(8'd100, 4'd9);
        wait_out(lat);
        chk("b2b_first", int'({bus.quotient, bus.remainder}), int'({8'd11, 4'd1}));
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.dividend = 8'd60;
        bus.divisor  = 4'd4;
        repeat (3) begin
            @(negedge clk);
            chk("b2b_blocked", int'(bus.in_ready), 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("b2b_idle_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("b2b_latency", lat, 9);
        chk("b2b_result", int'({bus.quotient, bus.remainder, bus.div_zero}), int'({8'd15, 4'd0, 1'b0}));
        release_out();

        // Abort an operation partway through CALC.
        send(8'd250, 4'd3);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_quotient", int'(bus.quotient), 0);
        chk("abort_remainder", int'(bus.remainder), 0);
        full_op(8'd250, 4'd3, 0, 1'b1, {8'd83, 4'd1, 1'b0});

        for (int k = 0; k < 120; k++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            full_op(a, b, int'($urandom_range(0, 3)), 1'b0, 13'd0);
        end

        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
